// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi sequencing controller: state encoding,
// parameter legality and modulo-address helpers.
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_MIN   = 2'd2,
        ST_TB    = 2'd3
    } vit_state_e;

    // Width of the min-search cycle counter; MIN_CYC tops out at 15.
    localparam int unsigned MIN_CNT_W = 4;

    // Address width for a DEPTH-entry survivor memory, never below one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // True when the parameter set describes a realisable controller.
    function automatic bit params_ok(input int unsigned depth,
                                     input int unsigned tb_len,
                                     input int unsigned min_cyc);
        return (depth >= 2) && (depth <= 256) &&
               (tb_len >= 1) && (tb_len <= depth) &&
               (min_cyc >= 1) && (min_cyc <= 15);
    endfunction

    // Previous address modulo depth (0 wraps to depth-1).
    function automatic int unsigned mod_dec(input int unsigned addr,
                                            input int unsigned depth);
        return (addr == 0) ? depth - 1 : addr - 1;
    endfunction

endpackage

// File: rtl/vit_mod_ptr.sv
// Modulo-DEPTH address pointer with synchronous load and up/down step.
// Load has priority over stepping; DEPTH need not be a power of two.
module vit_mod_ptr #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer value: load, wrap-around increment or wrap-around decrement.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end else if (dec_i) begin
            ptr_d = (ptr_q == '0) ? AW'(DEPTH - 1) : ptr_q - AW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/viterbi_seq_ctrl.sv
// Viterbi decoder sequencing controller: fills a survivor-memory window,
// grants the min-metric search a fixed number of cycles, then walks the
// traceback addresses backwards, in block or continuous mode.
module viterbi_seq_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TB_LEN  = 8,
    parameter int unsigned MIN_CYC = 1,
    localparam int unsigned AW     = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] wr_addr,
    output logic          min_req,
    input  logic          out_ready,
    output logic          te,
    output logic [AW-1:0] tb_addr,
    output logic          oe,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned TCW = $clog2(TB_LEN + 1);

    // Refuse to elaborate an unrealisable configuration.
    if (!params_ok(DEPTH, TB_LEN, MIN_CYC)) begin : g_bad_params
        $fatal(1, "viterbi_seq_ctrl: illegal DEPTH/TB_LEN/MIN_CYC combination");
    end

    vit_state_e           state_q;
    logic                 mode_q;
    logic [CW-1:0]        wr_cnt_q;
    logic [TCW-1:0]       tb_cnt_q;
    logic [MIN_CNT_W-1:0] min_cnt_q;
    logic                 in_ready_q;
    logic                 min_req_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept;
    logic                 step;
    logic                 last_sym;
    logic                 min_last;
    logic                 last_step;
    logic                 wr_load;
    logic                 tb_load;
    logic [AW-1:0]        tb_load_val;

    // Mealy handshakes: abort gates both write and traceback in its own cycle.
    assign accept = in_valid & in_ready_q & ~abort;
    assign step   = out_ready & (state_q == ST_TB) & ~abort;

    assign we       = accept;
    assign te       = step;
    assign oe       = step;
    assign in_ready = in_ready_q;
    assign min_req  = min_req_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Window boundary detection and pointer load controls.
    always_comb begin
        last_sym    = accept && (wr_cnt_q == CW'(DEPTH - 1));
        min_last    = (state_q == ST_MIN) && (min_cnt_q == MIN_CNT_W'(MIN_CYC - 1));
        last_step   = step && (tb_cnt_q == TCW'(1));
        wr_load     = abort || ((state_q == ST_IDLE) && start);
        tb_load     = abort || min_last;
        tb_load_val = abort ? '0 : AW'(mod_dec(32'(wr_addr), DEPTH));
    end

    vit_mod_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wr_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wr_load),
        .load_val_i ({AW{1'b0}}),
        .inc_i      (accept),
        .dec_i      (1'b0),
        .ptr_o      (wr_addr)
    );

    vit_mod_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tb_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tb_load),
        .load_val_i (tb_load_val),
        .inc_i      (1'b0),
        .dec_i      (step),
        .ptr_o      (tb_addr)
    );

    // Session FSM with counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            wr_cnt_q   <= '0;
            tb_cnt_q   <= '0;
            min_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            min_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q    <= ST_IDLE;
                wr_cnt_q   <= '0;
                tb_cnt_q   <= '0;
                min_cnt_q  <= '0;
                in_ready_q <= 1'b0;
                min_req_q  <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q    <= ST_STORE;
                            mode_q     <= mode;
                            wr_cnt_q   <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_STORE: begin
                        if (accept) begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                            if (last_sym) begin
                                state_q    <= ST_MIN;
                                in_ready_q <= 1'b0;
                                min_req_q  <= 1'b1;
                                min_cnt_q  <= '0;
                            end
                        end
                    end
                    ST_MIN: begin
                        if (min_last) begin
                            state_q   <= ST_TB;
                            min_req_q <= 1'b0;
                            min_cnt_q <= '0;
                            tb_cnt_q  <= TCW'(TB_LEN);
                        end else begin
                            min_cnt_q <= min_cnt_q + MIN_CNT_W'(1);
                        end
                    end
                    ST_TB: begin
                        if (step) begin
                            tb_cnt_q <= tb_cnt_q - TCW'(1);
                            if (last_step) begin
                                if (mode_q) begin
                                    state_q    <= ST_STORE;
                                    wr_cnt_q   <= '0;
                                    in_ready_q <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Directed bench for viterbi_seq_ctrl: a DEPTH=8/TB_LEN=6/MIN_CYC=2 instance
// and a DEPTH=6 instance share stimulus; sel6 picks which one is observed.
module tb_viterbi_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start, mode, abort, in_valid, out_ready;

    logic       in_ready8, we8, min_req8, te8, oe8, busy8, done8;
    logic [2:0] wr_addr8, tb_addr8;
    logic       in_ready6, we6, min_req6, te6, oe6, busy6, done6;
    logic [2:0] wr_addr6, tb_addr6;

    logic       sel6;
    logic       o_in_ready, o_we, o_min_req, o_te, o_oe, o_busy, o_done;
    logic [2:0] o_wr_addr, o_tb_addr;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        start;
        logic        mode;
        logic        abort;
        logic        in_valid;
        logic        out_ready;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    viterbi_seq_ctrl #(.DEPTH(8), .TB_LEN(6), .MIN_CYC(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready8), .we(we8), .wr_addr(wr_addr8),
        .min_req(min_req8), .out_ready(out_ready), .te(te8), .tb_addr(tb_addr8),
        .oe(oe8), .busy(busy8), .done(done8)
    );

    viterbi_seq_ctrl #(.DEPTH(6), .TB_LEN(6), .MIN_CYC(2)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready6), .we(we6), .wr_addr(wr_addr6),
        .min_req(min_req6), .out_ready(out_ready), .te(te6), .tb_addr(tb_addr6),
        .oe(oe6), .busy(busy6), .done(done6)
    );

    always_comb begin
        if (sel6) begin
            o_in_ready = in_ready6; o_we = we6; o_wr_addr = wr_addr6; o_min_req = min_req6;
            o_te = te6; o_oe = oe6; o_tb_addr = tb_addr6; o_busy = busy6; o_done = done6;
        end else begin
            o_in_ready = in_ready8; o_we = we8; o_wr_addr = wr_addr8; o_min_req = min_req8;
            o_te = te8; o_oe = oe8; o_tb_addr = tb_addr8; o_busy = busy8; o_done = done8;
        end
    end

    function automatic logic [11:0] obs();
        return {o_in_ready, o_we, o_wr_addr, o_min_req, o_te, o_tb_addr, o_busy, o_done};
    endfunction

    function automatic logic [11:0] ex(input logic ir, input logic w, input int wa,
                                       input logic mr, input logic t, input int ta,
                                       input logic b, input logic d);
        return {ir, w, 3'(wa), mr, t, 3'(ta), b, d};
    endfunction

    function automatic vec_t mkv(input logic s, input logic m, input logic a,
                                 input logic iv, input logic ordy, input logic [11:0] e);
        vec_t v;
        v.start = s; v.mode = m; v.abort = a; v.in_valid = iv; v.out_ready = ordy; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Abort cycle to bring both instances back to IDLE.
    task automatic sync_idle();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        chk("sync_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_start(input logic m);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One window from STORE entry: depth writes, 2 MIN cycles, 'steps' TB steps.
    task automatic window(input int depth, input int steps);
        for (int k = 0; k < depth; k++) begin
            in_valid = 1'b1; #2;
            chk("store_we", 32'(o_we), 32'd1);
            chk("store_addr", 32'(o_wr_addr), 32'(k));
            chk("store_busy", 32'(o_busy), 32'd1);
            @(negedge clk);
        end
        for (int m = 0; m < 2; m++) begin
            #2;
            chk("min_req", 32'(o_min_req), 32'd1);
            chk("min_no_we", 32'(o_we), 32'd0);
            chk("min_no_ready", 32'(o_in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int s = 0; s < steps; s++) begin
            #2;
            chk("tb_te", 32'(o_te), 32'd1);
            chk("tb_oe", 32'(o_oe), 32'd1);
            chk("tb_addr", 32'(o_tb_addr), 32'(depth - 1 - s));
            chk("tb_no_done", 32'(o_done), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int exp_tb;
        int n_te;
        int early;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sel6 = 1'b0;

        tbl[0] = mkv(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl[1 + k] = mkv(0, 0, 0, 1, 0, ex(1, 1, k, 0, 0, 0, 1, 0));
        tbl[9]  = mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 1, 0, 0, 1, 0));
        tbl[10] = mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 1, 0, 0, 1, 0));
        for (int s = 0; s < 6; s++) tbl[11 + s] = mkv(0, 0, 0, 0, 1, ex(0, 0, 0, 0, 1, 7 - s, 1, 0));
        tbl[17] = mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 1, 0, 1));
        tbl[18] = mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 1, 0, 0));

        #2;
        chk("reset_low_outputs", 32'(obs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("reset_state8", 32'(obs()), 32'd0);
        sel6 = 1'b1; #1;
        chk("reset_state6", 32'(obs()), 32'd0);
        sel6 = 1'b0;
        @(negedge clk);

        // Block-mode window, cycle by cycle.
        for (int i = 0; i < 19; i++) begin
            start = tbl[i].start; mode = tbl[i].mode; abort = tbl[i].abort;
            in_valid = tbl[i].in_valid; out_ready = tbl[i].out_ready;
            #2;
            chk($sformatf("blk[%0d]", i), 32'(obs()), 32'(tbl[i].exp));
            chk($sformatf("blk_oe[%0d]", i), 32'(o_oe), 32'(o_te));
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sync_idle();

        // Backpressure during traceback.
        do_start(1'b0);
        window(8, 0);
        exp_tb = 7; n_te = 0; early = 0;
        for (int c = 0; c < 20 && n_te < 6; c++) begin
            out_ready = (c % 2 == 0);
            #2;
            if (o_te) begin
                chk("bp_step_addr", 32'(o_tb_addr), 32'(exp_tb));
                exp_tb--;
                n_te++;
            end else begin
                chk("bp_stall_hold", 32'(o_tb_addr), 32'(exp_tb));
            end
            if (o_done) early = 1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("bp_te_count", 32'(n_te), 32'd6);
        chk("bp_no_early_done", 32'(early), 32'd0);
        #2;
        chk("bp_done", 32'(o_done), 32'd1);
        chk("bp_busy_low", 32'(o_busy), 32'd0);
        @(negedge clk);
        #2;
        chk("bp_done_pulse", 32'(o_done), 32'd0);
        @(negedge clk);

        // Continuous mode, two windows.
        sync_idle();
        do_start(1'b1);
        window(8, 6);
        #2;
        chk("cont_busy", 32'(o_busy), 32'd1);
        chk("cont_ready", 32'(o_in_ready), 32'd1);
        chk("cont_no_done", 32'(o_done), 32'd0);
        chk("cont_tb_end", 32'(o_tb_addr), 32'd1);
        @(negedge clk);
        window(8, 6);
        #2;
        chk("cont2_busy", 32'(o_busy), 32'd1);
        chk("cont2_no_done", 32'(o_done), 32'd0);
        @(negedge clk);
        sync_idle();

        // Abort on the 4th stored symbol.
        do_start(1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; #2;
            chk("ab_pre_addr", 32'(o_wr_addr), 32'(k));
            @(negedge clk);
        end
        abort = 1'b1; #2;
        chk("ab_no_we", 32'(o_we), 32'd0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; #2;
        chk("ab_idle", 32'(obs()), 32'd0);
        @(negedge clk);
        #2;
        chk("ab_no_done", 32'(o_done), 32'd0);
        @(negedge clk);
        do_start(1'b0);
        window(8, 6);
        #2;
        chk("ab_restart_done", 32'(o_done), 32'd1);
        @(negedge clk);

        // Start and abort together: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; #2;
        chk("sa_busy", 32'(o_busy), 32'd0);
        chk("sa_ready", 32'(o_in_ready), 32'd0);
        @(negedge clk);

        // Start and mode change while busy are ignored.
        do_start(1'b0);
        start = 1'b1; mode = 1'b1;
        window(8, 6);
        #2;
        chk("busy_mode_done", 32'(o_done), 32'd1);
        chk("busy_mode_idle", 32'(o_busy), 32'd0);
        start = 1'b0; mode = 1'b0;
        @(negedge clk);
        sync_idle();

        // Non-power-of-two depth wrap.
        sel6 = 1'b1;
        do_start(1'b1);
        window(6, 6);
        #2;
        chk("d6_wrap1", 32'(o_tb_addr), 32'd5);
        chk("d6_busy1", 32'(o_busy), 32'd1);
        @(negedge clk);
        window(6, 6);
        #2;
        chk("d6_wrap2", 32'(o_tb_addr), 32'd5);
        chk("d6_no_done", 32'(o_done), 32'd0);
        @(negedge clk);
        sel6 = 1'b0;
        sync_idle();

        // Reset in the middle of traceback.
        do_start(1'b0);
        window(8, 2);
        out_ready = 1'b1; #2;
        chk("rst_pre_te", 32'(o_te), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_async", 32'(obs()), 32'd0);
        chk("rst_async_oe", 32'(o_oe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0; #2;
        chk("rst_after", 32'(obs()), 32'd0);
        @(negedge clk);
        do_start(1'b0);
        window(8, 6);
        #2;
        chk("rst_restart_done", 32'(o_done), 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_seq_ctrl.md
VITERBI_SEQ_CTRL -- requirements
Module: viterbi_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: survivor-memory entries per window; legal range 2..256.
REQ-002 Parameter TB_LEN, default 8: traceback steps per window; legal range 1..DEPTH.
REQ-003 Parameter MIN_CYC, default 1: cycles granted to the min-metric search; legal range 1..15.
REQ-004 Derived constant AW = clog2(DEPTH), minimum 1.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  begin a decode session; sampled only in IDLE.
REQ-008 mode  in  1  0 = block (one window, then stop), 1 = continuous (windows repeat); latched when start is accepted.
REQ-009 abort  in  1  synchronous session cancel.
REQ-010 in_valid  in  1  branch-decision symbol available.
REQ-011 in_ready  out  1  controller accepts a symbol this cycle.
REQ-012 we  out  1  survivor-memory write enable, equal to in_valid AND in_ready.
REQ-013 wr_addr  out  AW  survivor-memory write address.
REQ-014 min_req  out  1  min-metric search active.
REQ-015 out_ready  in  1  downstream bit sink can accept.
REQ-016 te  out  1  traceback step enable.
REQ-017 tb_addr  out  AW  survivor-memory read address.
REQ-018 oe  out  1  decoded-bit valid; equal to te.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at block-mode completion.

Function
REQ-021 The FSM SHALL have four states: IDLE, STORE, MIN, TB.
REQ-022 IDLE: all outputs low; start=1 -> STORE, latch mode, clear wr_addr and wr_cnt.
REQ-023 STORE: in_ready=1; each accepted symbol increments wr_addr modulo DEPTH and increments wr_cnt.
REQ-024 STORE -> MIN on the cycle in which the DEPTH-th symbol of the window is accepted; in_ready drops the next cycle.
REQ-025 MIN: min_req=1 for exactly MIN_CYC cycles, then -> TB; load tb_addr = wr_addr-1 modulo DEPTH and tb_cnt = TB_LEN.
REQ-026 TB: te=oe=out_ready; each step decrements tb_addr modulo DEPTH and decrements tb_cnt; out_ready=0 stalls with no state change.
REQ-027 TB exit on the step with tb_cnt=1: block mode -> IDLE with done=1 for one cycle; continuous mode -> STORE with wr_cnt cleared and wr_addr preserved.
REQ-028 in_ready SHALL be 0 in IDLE, MIN, and TB; in_valid in those states SHALL be ignored with no write.
REQ-029 abort=1 in any state SHALL force IDLE next cycle, clear all counters, suppress done, and gate we/te/oe low in the abort cycle.
REQ-030 Simultaneous abort and start: abort wins; the controller stays in IDLE.
REQ-031 start while busy SHALL be ignored; mode changes while busy SHALL be ignored.
REQ-032 Address wrap: DEPTH-1 +1 -> 0 and 0 -1 -> DEPTH-1, including non-power-of-two DEPTH.
REQ-033 The outputs in_ready, min_req, busy, and done SHALL be decoded from registered state; we, te, and oe SHALL be Mealy outputs (combinational on in_valid, out_ready, abort).

Reset
REQ-034 rst_n low SHALL immediately set state=IDLE, wr_addr=0, tb_addr=0, all counters 0, and latched mode=0, driving all outputs low, including mid-window.
REQ-035 After rst_n deasserts, the first start SHALL behave as from power-up.

Structure
REQ-036 State encodings and parameter legality checks SHALL reside in shared package viterbi_pkg.
REQ-037 One sub-module, vit_mod_ptr (a parametrised modulo-DEPTH up/down pointer with load), SHALL be instantiated twice: once for wr_addr and once for tb_addr.
REQ-038 Elaboration SHALL fail if TB_LEN > DEPTH or MIN_CYC = 0.

Verification (DEPTH=8, TB_LEN=6, MIN_CYC=2)
REQ-039 Block mode: start, 8 back-to-back valid symbols -> we on wr_addr 0..7; min_req high for 2 cycles; te on tb_addr 7,6,5,4,3,2; done one cycle later; busy low.
REQ-040 Backpressure: out_ready toggles 1,0,1,0 during TB -> exactly 6 te pulses; tb_addr holds during stalls; no done before the 6th step.
REQ-041 Continuous mode: 2 windows -> second window writes wr_addr 0..7 (wrap after 7), traceback reads 7..2 again; no done; busy stays high.
REQ-042 DEPTH=6 wrap: continuous mode, second window tb_addr sequence 5,4,3,2,1,0; pointer decrement from 0 wraps to 5.
REQ-043 abort on 4th STORE symbol with in_valid=1 -> no write that cycle; IDLE next cycle; wr_addr=0; no done; new start then restarts at wr_addr 0.
REQ-044 rst_n low during TB -> all outputs 0 asynchronously; in_valid during MIN or TB never produces we.
